pu_ctrl: RTL and testbench
==========================

# pu_ctrl

Sequencer for one processing unit (MAC cluster + weight memory + result memory). It accepts a layer command, then walks the partial-sum passes and cache entries. It drives the weight read address, bias select, MAC cluster cache addresses and flags, and result-memory writes. It back-pressures the upstream data feeder one beat per MAC operation.

## Interface
Parameters:
- WADDR_WIDTH, 7, weight memory address width
- RADDR_WIDTH, 6, result memory address width
- WB_LAT, 2, cycles from a MAC beat reaching the cluster to its total sum being valid for rmem write (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_num_pass_m1  in  5  partial-sum passes per output, minus 1 (1..32)
- cfg_num_out_m1  in  5  outputs (cache entries) per command, minus 1 (1..32)
- cfg_w_base  in  WADDR_WIDTH  first weight row
- cfg_r_base  in  RADDR_WIDTH  first rmem row
- cfg_bias_en  in  1  add bias on last pass
- cfg_relu  in  1  ReLU on last pass
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when command completes
- data_valid  in  1  feeder has a beat
- data_ready  out  1  controller accepts a beat (high only in RUN)
- pu_w_rd_addr  out  WADDR_WIDTH  weight read address
- pu_mac_valid  out  1  MAC beat qualifier / cache write enable
- pu_cache_clear  out  1  clear MAC cache
- pu_cache_rd_addr, pu_cache_wr_addr  out  5  cache entry
- pu_bias_addr  out  3  bias lane select
- pu_add_bias, pu_relu, pu_done  out  1  MAC flags
- pu_r_wr_en  out  1  rmem write enable
- pu_r_wr_addr  out  RADDR_WIDTH  rmem write address

## Operation
- FSM states:
  - IDLE: cfg_start → CLEAR. All cfg_* are latched on the start cycle.
  - CLEAR: one cycle; pu_cache_clear=1 → RUN.
  - RUN: issue beats. After the last beat fires → DRAIN.
  - DRAIN: wait until the write-back delay line is empty → DONE.
  - DONE: one cycle; done=1 → IDLE.
- Loop order: pass p outer (0..P-1), output o inner (0..O-1). Total P·O beats.
- Beat fires when data_valid && data_ready. Only then do the counters advance. No fire means no state change.
- Weight address is a linear counter from w_base, +1 per beat, wrapping modulo 2^WADDR_WIDTH.
- Per beat:
  - cache_rd_addr = cache_wr_addr = o; bias_addr = o[2:0].
  - On the last pass (p = P-1): pu_done=1, pu_add_bias=bias_en, pu_relu=relu. Otherwise all three are 0.
- Write-back: each beat on the last pass pushes {1, r_base+o} into a WB_LAT-deep shift line. Its output drives pu_r_wr_en / pu_r_wr_addr. The rmem address wraps modulo 2^RADDR_WIDTH.
- cfg_start while busy is ignored.
- Reset (any time, including mid-command): state IDLE, counters and delay line cleared. Every output is 0, including pu_w_rd_addr and data_ready.

## Timing
- Beat fires at cycle t: pu_w_rd_addr is valid combinationally at t. The wmem read is synchronous, so weights reach the cluster at t+1.
- pu_mac_valid and all per-beat MAC controls are registered and valid at t+1, aligned with the weights. The feeder must drive in_data for that beat at t+1.
- pu_r_wr_en for a last-pass beat at t is asserted at t+1+WB_LAT.
- Start at cycle s: CLEAR at s+1, data_ready first high at s+2.
- With no stalls, done pulses at s+2+P·O+WB_LAT+1. busy falls the cycle after done.
- Outputs between beats: pu_mac_valid, pu_done, pu_add_bias and pu_relu are 0. Address outputs hold their last value.

## Configuration
- PU_CTRL_STALL_CNT_EN:
  - Defined: adds output stall_cnt [15:0]. It counts RUN cycles with data_valid=0, saturates at 16'hFFFF, clears to 0 on an accepted start, holds after done, and resets to 0.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Basic: P=2, O=4, w_base=10, r_base=5, bias_en=1, relu=1, data_valid always 1.
  - Expect 8 beats with w_rd_addr 10..17.
  - pu_done/add_bias/relu high only on beats 5–8.
  - r_wr_en at addrs 5,6,7,8, each WB_LAT+1 cycles after its beat.
  - done at s+13 with WB_LAT=2.
- Stalls: same command with data_valid toggling 1,0,1,0.
  - Expect identical beat sequence and addresses; no pu_mac_valid during stall cycles.
  - done delayed by exactly the number of stalls.
  - stall_cnt equals the stall count when the macro is on.
- Wrap: w_base=126, P=1, O=4, r_base=62.
  - Expect w_rd_addr 126,127,0,1; r_wr_addr 62,63,0,1.
- Extremes: P=32, O=32 (all cfg_*_m1=31).
  - Expect 1024 beats, cache addr cycling 0..31 each pass.
  - bias_addr = o[2:0]; 32 rmem writes.
- Start while busy: second cfg_start mid-RUN.
  - Expect it ignored; beat count unchanged.
- Reset mid-RUN: assert rst after 3 beats.
  - Expect all outputs 0 immediately and no further r_wr_en.
  - A new start after release runs a full, correct command.

Source files
------------

// File: rtl/pu_ctrl.sv
// Processing-unit sequencer: walks passes x outputs, drives MAC/cache/rmem controls.
// Optional stall counter output enabled by defining PU_CTRL_STALL_CNT_EN.
module pu_ctrl #(
    parameter int WADDR_WIDTH = 7,
    parameter int RADDR_WIDTH = 6,
    parameter int WB_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [4:0]             cfg_num_pass_m1,
    input  logic [4:0]             cfg_num_out_m1,
    input  logic [WADDR_WIDTH-1:0] cfg_w_base,
    input  logic [RADDR_WIDTH-1:0] cfg_r_base,
    input  logic                   cfg_bias_en,
    input  logic                   cfg_relu,
    output logic                   busy,
    output logic                   done,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [WADDR_WIDTH-1:0] pu_w_rd_addr,
    output logic                   pu_mac_valid,
    output logic                   pu_cache_clear,
    output logic [4:0]             pu_cache_rd_addr,
    output logic [4:0]             pu_cache_wr_addr,
    output logic [2:0]             pu_bias_addr,
    output logic                   pu_add_bias,
    output logic                   pu_relu,
    output logic                   pu_done,
    output logic                   pu_r_wr_en,
    output logic [RADDR_WIDTH-1:0] pu_r_wr_addr
`ifdef PU_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r;
    logic [4:0]             pass_m1_r;
    logic [4:0]             out_m1_r;
    logic [RADDR_WIDTH-1:0] r_base_r;
    logic                   bias_en_r;
    logic                   relu_r;
    logic [4:0]             p_cnt_r;
    logic [4:0]             o_cnt_r;

    logic [WB_LAT-1:0]      wb_v_r;
    logic [RADDR_WIDTH-1:0] wb_a_r [WB_LAT];

    logic                   fire_s;
    logic                   last_pass_s;
    logic                   last_out_s;
    logic                   last_beat_s;
    logic                   wb_push_s;
    logic                   wb_pending_s;
    logic [RADDR_WIDTH-1:0] wb_addr_s;

    // Beat handshake and loop-position decode.
    always_comb begin
        fire_s       = data_valid && data_ready;
        last_pass_s  = (p_cnt_r == pass_m1_r);
        last_out_s   = (o_cnt_r == out_m1_r);
        last_beat_s  = last_pass_s && last_out_s;
        wb_push_s    = fire_s && last_pass_s;
        wb_pending_s = |wb_v_r;
        wb_addr_s    = r_base_r + RADDR_WIDTH'(o_cnt_r);
    end

    // Command FSM: config latch, loop counters, weight address, handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            data_ready     <= 1'b0;
            pu_cache_clear <= 1'b0;
            pu_w_rd_addr   <= {WADDR_WIDTH{1'b0}};
            pass_m1_r      <= 5'd0;
            out_m1_r       <= 5'd0;
            r_base_r       <= {RADDR_WIDTH{1'b0}};
            bias_en_r      <= 1'b0;
            relu_r         <= 1'b0;
            p_cnt_r        <= 5'd0;
            o_cnt_r        <= 5'd0;
        end else begin
            done           <= 1'b0;
            pu_cache_clear <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_r        <= S_CLEAR;
                        busy           <= 1'b1;
                        pu_cache_clear <= 1'b1;
                        pass_m1_r      <= cfg_num_pass_m1;
                        out_m1_r       <= cfg_num_out_m1;
                        r_base_r       <= cfg_r_base;
                        bias_en_r      <= cfg_bias_en;
                        relu_r         <= cfg_relu;
                        pu_w_rd_addr   <= cfg_w_base;
                        p_cnt_r        <= 5'd0;
                        o_cnt_r        <= 5'd0;
                    end
                end
                S_CLEAR: begin
                    state_r    <= S_RUN;
                    data_ready <= 1'b1;
                end
                S_RUN: begin
                    if (fire_s) begin
                        pu_w_rd_addr <= pu_w_rd_addr + {{(WADDR_WIDTH-1){1'b0}}, 1'b1};
                        if (last_out_s) begin
                            o_cnt_r <= 5'd0;
                            p_cnt_r <= p_cnt_r + 5'd1;
                        end else begin
                            o_cnt_r <= o_cnt_r + 5'd1;
                        end
                        if (last_beat_s) begin
                            state_r    <= S_DRAIN;
                            data_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!wb_pending_s) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r    <= S_IDLE;
                    busy       <= 1'b0;
                    data_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-beat MAC controls, registered to line up with the synchronous weight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_mac_valid     <= 1'b0;
            pu_done          <= 1'b0;
            pu_add_bias      <= 1'b0;
            pu_relu          <= 1'b0;
            pu_cache_rd_addr <= 5'd0;
            pu_cache_wr_addr <= 5'd0;
            pu_bias_addr     <= 3'd0;
        end else begin
            pu_mac_valid <= fire_s;
            pu_done      <= wb_push_s;
            pu_add_bias  <= wb_push_s && bias_en_r;
            pu_relu      <= wb_push_s && relu_r;
            if (fire_s) begin
                pu_cache_rd_addr <= o_cnt_r;
                pu_cache_wr_addr <= o_cnt_r;
                pu_bias_addr     <= o_cnt_r[2:0];
            end
        end
    end

    // Write-back delay line; final output register holds the address between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_v_r       <= {WB_LAT{1'b0}};
            for (int i = 0; i < WB_LAT; i++) begin
                wb_a_r[i] <= {RADDR_WIDTH{1'b0}};
            end
            pu_r_wr_en   <= 1'b0;
            pu_r_wr_addr <= {RADDR_WIDTH{1'b0}};
        end else begin
            wb_v_r[0] <= wb_push_s;
            wb_a_r[0] <= wb_addr_s;
            for (int i = 1; i < WB_LAT; i++) begin
                wb_v_r[i] <= wb_v_r[i-1];
                wb_a_r[i] <= wb_a_r[i-1];
            end
            pu_r_wr_en <= wb_v_r[WB_LAT-1];
            if (wb_v_r[WB_LAT-1]) begin
                pu_r_wr_addr <= wb_a_r[WB_LAT-1];
            end
        end
    end

`ifdef PU_CTRL_STALL_CNT_EN
    // Saturating count of RUN cycles where the feeder had nothing to offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if ((state_r == S_IDLE) && cfg_start) begin
            stall_cnt <= 16'd0;
        end else if ((state_r == S_RUN) && !data_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pu_ctrl.sv
// Scoreboard bench for pu_ctrl: beats and rmem writes are predicted from the command
// and popped as the DUT produces them.
module tb_pu_ctrl;

    localparam int WB_LAT = 2;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [4:0]  cfg_num_pass_m1;
    logic [4:0]  cfg_num_out_m1;
    logic [6:0]  cfg_w_base;
    logic [5:0]  cfg_r_base;
    logic        cfg_bias_en;
    logic        cfg_relu;
    logic        busy;
    logic        done;
    logic        data_valid;
    logic        data_ready;
    logic [6:0]  pu_w_rd_addr;
    logic        pu_mac_valid;
    logic        pu_cache_clear;
    logic [4:0]  pu_cache_rd_addr;
    logic [4:0]  pu_cache_wr_addr;
    logic [2:0]  pu_bias_addr;
    logic        pu_add_bias;
    logic        pu_relu;
    logic        pu_done;
    logic        pu_r_wr_en;
    logic [5:0]  pu_r_wr_addr;
`ifdef PU_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pu_ctrl #(.WADDR_WIDTH(7), .RADDR_WIDTH(6), .WB_LAT(WB_LAT)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_num_pass_m1(cfg_num_pass_m1), .cfg_num_out_m1(cfg_num_out_m1),
        .cfg_w_base(cfg_w_base), .cfg_r_base(cfg_r_base),
        .cfg_bias_en(cfg_bias_en), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .data_valid(data_valid), .data_ready(data_ready),
        .pu_w_rd_addr(pu_w_rd_addr), .pu_mac_valid(pu_mac_valid),
        .pu_cache_clear(pu_cache_clear), .pu_cache_rd_addr(pu_cache_rd_addr),
        .pu_cache_wr_addr(pu_cache_wr_addr), .pu_bias_addr(pu_bias_addr),
        .pu_add_bias(pu_add_bias), .pu_relu(pu_relu), .pu_done(pu_done),
        .pu_r_wr_en(pu_r_wr_en), .pu_r_wr_addr(pu_r_wr_addr)
`ifdef PU_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    wire [34:0] all_outs = {busy, done, data_ready, pu_w_rd_addr, pu_mac_valid, pu_cache_clear,
                            pu_cache_rd_addr, pu_cache_wr_addr, pu_bias_addr, pu_add_bias,
                            pu_relu, pu_done, pu_r_wr_en, pu_r_wr_addr};

    typedef struct { int o; bit last; } beat_t;
    typedef struct { int c; int a; } wr_t;

    beat_t bq[$];
    wr_t   wq[$];
    int    cyc;
    int    n_checks;
    int    n_fail;
    int    hold_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Run one command; checks every cycle from start until the expected done pulse.
    task automatic run_cmd(input string name, input int np, input int no, input int wb,
                           input int rb, input bit be, input bit rl, input bit stall_mode,
                           input bit dup);
        int s, c, k, total, exp_done, exp_stalls, budget;
        bit fire, fire_prev, exp_ready, dv, exp_en;
        beat_t b;
        wr_t w;
        total = np * no; k = 0; exp_done = -1; exp_stalls = 0; fire_prev = 1'b0;
        budget = 4 * total + 40;
        bq.delete(); wq.delete();
        @(negedge clk);
        s = cyc;
        cfg_num_pass_m1 = 5'(np - 1); cfg_num_out_m1 = 5'(no - 1);
        cfg_w_base = 7'(wb); cfg_r_base = 6'(rb); cfg_bias_en = be; cfg_relu = rl;
        forever begin
            c = cyc;
            exp_ready = (c >= s + 2) && (k < total);
            n_checks++;
            if (data_ready !== exp_ready) begin
                n_fail++; $display("FAIL %s data_ready @%0d: got %0b want %0b", name, c - s, data_ready, exp_ready);
            end
            n_checks++;
            if (pu_mac_valid !== fire_prev) begin
                n_fail++; $display("FAIL %s mac_valid @%0d: got %0b want %0b", name, c - s, pu_mac_valid, fire_prev);
            end
            if (fire_prev && bq.size() > 0) begin
                b = bq.pop_front();
                hold_o = b.o;
                n_checks++;
                if ({pu_cache_rd_addr, pu_cache_wr_addr, pu_bias_addr} !== {5'(b.o), 5'(b.o), 3'(b.o)}) begin
                    n_fail++; $display("FAIL %s cache/bias addr @%0d: got %0d/%0d/%0d want o=%0d", name, c - s,
                                       pu_cache_rd_addr, pu_cache_wr_addr, pu_bias_addr, b.o);
                end
                n_checks++;
                if ({pu_done, pu_add_bias, pu_relu} !== {b.last, b.last && be, b.last && rl}) begin
                    n_fail++; $display("FAIL %s mac flags @%0d: got %b want %b", name, c - s,
                                       {pu_done, pu_add_bias, pu_relu}, {b.last, b.last && be, b.last && rl});
                end
            end else begin
                n_checks++;
                if ({pu_done, pu_add_bias, pu_relu} !== 3'b000 || pu_cache_wr_addr !== 5'(hold_o)) begin
                    n_fail++; $display("FAIL %s idle flags/hold @%0d: got %b addr %0d want 000 addr %0d", name, c - s,
                                       {pu_done, pu_add_bias, pu_relu}, pu_cache_wr_addr, hold_o);
                end
            end
            n_checks++;
            if (pu_cache_clear !== (c == s + 1)) begin
                n_fail++; $display("FAIL %s cache_clear @%0d: got %0b want %0b", name, c - s, pu_cache_clear, c == s + 1);
            end
            n_checks++;
            if (busy !== (c >= s + 1)) begin
                n_fail++; $display("FAIL %s busy @%0d: got %0b want %0b", name, c - s, busy, c >= s + 1);
            end
            n_checks++;
            if (done !== (c == exp_done)) begin
                n_fail++; $display("FAIL %s done @%0d: got %0b want %0b", name, c - s, done, c == exp_done);
            end
            exp_en = (wq.size() > 0) && (wq[0].c == c);
            n_checks++;
            if (pu_r_wr_en !== exp_en) begin
                n_fail++; $display("FAIL %s r_wr_en @%0d: got %0b want %0b", name, c - s, pu_r_wr_en, exp_en);
            end
            if (exp_en) begin
                w = wq.pop_front();
                n_checks++;
                if (pu_r_wr_addr !== 6'(w.a)) begin
                    n_fail++; $display("FAIL %s r_wr_addr @%0d: got %0d want %0d", name, c - s, pu_r_wr_addr, w.a);
                end
            end
`ifdef PU_CTRL_STALL_CNT_EN
            if (c == s + 1 || c == exp_done) begin
                n_checks++;
                if (stall_cnt !== 16'((c == exp_done) ? exp_stalls : 0)) begin
                    n_fail++; $display("FAIL %s stall_cnt @%0d: got %0d want %0d", name, c - s, stall_cnt,
                                       (c == exp_done) ? exp_stalls : 0);
                end
            end
`endif
            if (c == exp_done) break;
            if (c - s > budget) begin
                n_checks++; n_fail++;
                $display("FAIL %s timeout: got %0d beats want %0d", name, k, total);
                break;
            end
            dv = stall_mode ? ((c - s) % 2 == 0) : 1'b1;
            data_valid = dv;
            cfg_start = (c == s) || (dup && c == s + 4);
            if (dup && c == s + 4) begin
                cfg_num_out_m1 = 5'd0; cfg_w_base = 7'd99; cfg_r_base = 6'd33;
            end
            fire = dv && exp_ready;
            if (exp_ready && !dv) exp_stalls++;
            if (fire) begin
                n_checks++;
                if (pu_w_rd_addr !== 7'((wb + k) % 128)) begin
                    n_fail++; $display("FAIL %s w_rd_addr beat %0d: got %0d want %0d", name, k, pu_w_rd_addr, (wb + k) % 128);
                end
                b.o = k % no; b.last = ((k / no) == np - 1);
                bq.push_back(b);
                if (b.last) begin
                    w.c = c + 1 + WB_LAT; w.a = (rb + b.o) % 64;
                    wq.push_back(w);
                end
                k++;
                if (k == total) exp_done = c + 2 + WB_LAT;
            end
            fire_prev = fire;
            @(negedge clk);
        end
        cfg_start = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, pu_r_wr_en, pu_mac_valid} !== 4'b0000 || bq.size() != 0 || wq.size() != 0) begin
            n_fail++; $display("FAIL %s after done: got busy/done/wr/mv=%b pending %0d/%0d want 0000 0/0", name,
                               {busy, done, pu_r_wr_en, pu_mac_valid}, bq.size(), wq.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs !== 35'd0) begin
            n_fail++; $display("FAIL reset outputs: got %h want 0", all_outs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (all_outs !== 35'd0) begin
            n_fail++; $display("FAIL post-reset idle: got %h want 0", all_outs);
        end
        hold_o = 0;
    endtask

    task automatic test_basic;
        run_cmd("basic", 2, 4, 10, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        run_cmd("stall", 2, 4, 10, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        run_cmd("wrap", 1, 4, 126, 62, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_extremes;
        run_cmd("extremes", 32, 32, 3, 17, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_busy;
        run_cmd("start_busy", 2, 4, 40, 20, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        int s;
        @(negedge clk);
        s = cyc;
        cfg_num_pass_m1 = 5'd1; cfg_num_out_m1 = 5'd3; cfg_w_base = 7'd10; cfg_r_base = 6'd5;
        cfg_bias_en = 1'b1; cfg_relu = 1'b1; cfg_start = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== 35'd0) begin
            n_fail++; $display("FAIL reset_mid immediate: got %h want 0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_o = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, pu_r_wr_en, pu_mac_valid, data_ready} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_mid quiet %0d: got %b want 0000", i, {busy, pu_r_wr_en, pu_mac_valid, data_ready});
            end
        end
        data_valid = 1'b0;
        run_cmd("after_reset", 2, 4, 10, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; hold_o = 0;
        rst = 1'b1; cfg_start = 1'b0; data_valid = 1'b0;
        cfg_num_pass_m1 = 5'd0; cfg_num_out_m1 = 5'd0; cfg_w_base = 7'd0; cfg_r_base = 6'd0;
        cfg_bias_en = 1'b0; cfg_relu = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_extremes();
        test_start_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
